// File: rtl/ascon_perm_scheduler.sv
// ascon_perm_scheduler
// Shares one combinational Ascon round core between two requesters. A
// round-robin arbiter accepts one job at a time in IDLE. The scheduler owns
// the state register and applies one round per clock while stepping the
// round-constant index. It then reports the permuted state with a
// one-cycle done pulse that is tagged with the owning requester.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   reqN_valid/ready  job handshake; ready is combinational and only high in IDLE
//   reqN_state        input state for requester N
//   reqN_rounds       round count for requester N; counts above ROUNDS_MAX are clamped
//   core_state_o      state register, fed to the round core
//   core_rc_idx       round-constant index, fed to the round core
//   core_state_i      round core output (combinational)
//   done, done_id     one-cycle result pulse and the requester that owns it
//   result            permuted state; same as core_state_o, held until next accept
//   busy              high in RUN and DONE
module ascon_perm_scheduler #(
   parameter int STATE_W    = 320,
   parameter int ROUNDS_MAX = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [STATE_W-1:0] req0_state,
   input  logic [4:0]         req0_rounds,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [STATE_W-1:0] req1_state,
   input  logic [4:0]         req1_rounds,
   output logic [STATE_W-1:0] core_state_o,
   output logic [3:0]         core_rc_idx,
   input  logic [STATE_W-1:0] core_state_i,
   output logic               done,
   output logic               done_id,
   output logic [STATE_W-1:0] result,
   output logic               busy
);

   localparam logic [4:0] RMAX = 5'(ROUNDS_MAX);

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   fsm_t               fsm_q, fsm_d;
   logic [STATE_W-1:0] st_q;
   logic [3:0]         rc_q;
   logic [4:0]         rem_q;
   logic               last_grant;
   logic               id_q;
   logic               idle;
   logic               grant;
   logic               grant_id;
   logic [4:0]         sel_rounds;
   logic [4:0]         r_clamp;
   logic [STATE_W-1:0] sel_state;

   // Mux the granted request. The readys are one-hot, so req1_ready alone
   // identifies the winner.
   always_comb begin
      grant      = req0_ready | req1_ready;
      grant_id   = req1_ready;
      sel_rounds = grant_id ? req1_rounds : req0_rounds;
      sel_state  = grant_id ? req1_state  : req0_state;
      r_clamp    = (sel_rounds > RMAX) ? RMAX : sel_rounds;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) fsm_q <= IDLE;
      else      fsm_q <= fsm_d;
   end

   // FSM next state
   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         IDLE:    if (grant) fsm_d = (r_clamp == 5'd0) ? DONE : RUN;
         RUN:     if (rem_q == 5'd1) fsm_d = DONE;
         DONE:    fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase
   end

   // FSM outputs. When both requesters are valid, the one that did not win
   // last time gets the grant. Gating with rst keeps the readys low while
   // reset is held.
   always_comb begin
      idle       = (fsm_q == IDLE) && rst;
      req0_ready = idle && req0_valid && (!req1_valid || last_grant);
      req1_ready = idle && req1_valid && (!req0_valid || !last_grant);
      done       = (fsm_q == DONE);
      busy       = (fsm_q != IDLE);
   end

   // Datapath: load on accept, apply one core round per RUN cycle. The
   // index starts at ROUNDS_MAX-r, so the last round always uses index
   // ROUNDS_MAX-1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q       <= '0;
         rc_q       <= '0;
         rem_q      <= '0;
         last_grant <= 1'b1;
         id_q       <= 1'b0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (grant) begin
                  st_q       <= sel_state;
                  last_grant <= grant_id;
                  id_q       <= grant_id;
                  rc_q       <= 4'(RMAX - r_clamp);
                  rem_q      <= r_clamp;
               end
            end
            RUN: begin
               st_q  <= core_state_i;
               rc_q  <= rc_q + 4'd1;
               rem_q <= rem_q - 5'd1;
            end
            DONE:    rc_q <= '0;
            default: rc_q <= '0;
         endcase
      end
   end

   assign core_state_o = st_q;
   assign result       = st_q;
   assign core_rc_idx  = rc_q;
   assign done_id      = id_q;

endmodule

// File: doc/ascon_perm_scheduler.md
Name: ascon_perm_scheduler

Overview:
- Shares one combinational single-round Ascon permutation core between two requesters, e.g. the AEAD engine and the hash engine.
- Arbitrates round-robin between requesters 0 and 1.
- Owns the 320-bit state register and iterates the core one round per clock, driving the round-constant index.
- Returns the permuted state with a one-cycle done pulse tagged with the requester ID.

Parameters:
STATE_W, 320, permutation state width in bits
ROUNDS_MAX, 12, maximum rounds per invocation; round-constant index space 0..ROUNDS_MAX-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req0_valid  input  1  requester 0 has a permutation job
req0_ready  output  1  requester 0 job accepted this cycle
req0_state  input  STATE_W  requester 0 input state
req0_rounds  input  5  requester 0 round count
req1_valid  input  1  requester 1 has a permutation job
req1_ready  output  1  requester 1 job accepted this cycle
req1_state  input  STATE_W  requester 1 input state
req1_rounds  input  5  requester 1 round count
core_state_o  output  STATE_W  state fed to the round core (the state register)
core_rc_idx  output  4  round-constant index fed to the round core
core_state_i  input  STATE_W  round core output, combinational from core_state_o and core_rc_idx
done  output  1  one-cycle pulse: result valid
done_id  output  1  requester that owns the result
result  output  STATE_W  permuted state; equals core_state_o
busy  output  1  high in RUN and DONE

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE.
  - All outputs and registers are cleared: state register, core_rc_idx, remaining count, done, done_id, busy, readys.
  - last_grant is set to 1, so requester 0 wins the first tie.
  - An in-flight job is dropped silently; no done is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - The readys are combinational and are asserted only in IDLE.
  - If exactly one req_valid is high, that requester is granted.
  - If both are high, the requester not equal to last_grant is granted.
  - The granted reqN_ready is high in the same cycle. At that clock edge:
    - state register <= reqN_state
    - last_grant <= N
    - done_id <= N
    - rounds are latched as follows:
      - r = min(reqN_rounds, 12)
      - core_rc_idx <= 12 - r
      - remaining <= r
  - If r = 0, go to DONE. Otherwise go to RUN.
  - The ungranted requester must hold valid and data stable until its ready. Valid may drop before grant with no effect.
- RUN:
  - Each cycle: state register <= core_state_i, core_rc_idx <= core_rc_idx + 1, remaining <= remaining - 1.
  - When remaining = 1, go to DONE.
  - The index sequence is 12-r .. 11 (12 rounds: 0..11; 6 rounds: 6..11; 8 rounds: 4..11).
- DONE:
  - done = 1 for exactly one cycle, then return to IDLE.
  - No acceptance in DONE. The earliest next accept is the cycle after DONE.
- Latency and throughput:
  - Accept edge at cycle T. Rounds are applied on edges T+1..T+r.
  - done is high during cycle T+r+1, when result is the final state.
  - A back-to-back job is accepted at T+r+2, so throughput is r+2 cycles per job.
- In IDLE, core_rc_idx is 0.
- result/core_state_o holds its value from DONE until the next accept.
- The round core is purely combinational. The scheduler adds no pipeline stage between core_state_i and the state register.

Test Plan:
- After reset, req0_valid with rounds=12 and a fixed 320-bit vector, stub core = golden Ascon round model:
  - req0_ready is high for 1 cycle.
  - core_rc_idx steps 0..11.
  - done is high 13 cycles after the accept edge, done_id=0.
  - result matches the golden p^12 output.
  - busy is high for 13 cycles.
- req1 with rounds=6:
  - core_rc_idx steps 6,7,8,9,10,11.
  - done 7 cycles after accept, done_id=1, result equals golden p^6.
- req0 and req1 valid together immediately after reset, both rounds=12:
  - req0 is granted first; req1 is accepted 14 cycles later (cycle after DONE).
  - Reassert both: req0 is granted, since last_grant=1.
  - Repeat once more: grants alternate 0,1,0,1.
- Boundary round counts:
  - rounds=0: done the cycle after accept, result equals the input state unchanged, no RUN cycles.
  - rounds=15: treated as 12 (rc_idx 0..11, done at T+13).
- Reset mid-operation: pull rst low during RUN at rc_idx=5:
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - No done pulse occurs.
  - After release, both requesters are valid: req0 is granted.
